// File: rtl/sw_acc_pkg.sv
// rtl/sw_acc_pkg.sv - register map and bit indices for the switch accumulator
package sw_acc_pkg;

  localparam logic [1:0] ADDR_ACC    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_SWVAL  = 2'd3;

  localparam int CTRL_SUB = 0;
  localparam int CTRL_SAT = 1;

  localparam int ST_OVF = 0;
  localparam int ST_CLR = 1;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronise and debounce one active-low button, emit a press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q;
  logic             stable_d;
  logic             stable_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;

  // Any cycle where the synchronised level agrees with the accepted state restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q       <= 1'b1;
      sync_q       <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      meta_q       <= btn_n_i;
      sync_q       <= meta_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
      press_q      <= stable_dly_q & ~stable_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/sw_accumulator_pio.sv
// rtl/sw_accumulator_pio.sv - switch accumulator peripheral with debounced buttons and Avalon-MM registers
module sw_accumulator_pio
  import sw_acc_pkg::*;
#(
  parameter int SW_W            = 8,
  parameter int ACC_W           = 16,
  parameter int LED_W           = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [SW_W-1:0]   sw_export,
  input  logic              acc_btn_n,
  input  logic              clr_btn_n,
  output logic [LED_W-1:0]  led_export,
  output logic [ACC_W-1:0]  acc_value,
  output logic              ovf,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata
);

  logic [SW_W-1:0]  sw_meta_q;
  logic [SW_W-1:0]  sw_sync_q;
  logic             acc_press;
  logic             clr_press;
  logic             acc_evt_q;
  logic             clr_evt_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic             ovf_q;
  logic             ovf_d;
  logic [1:0]       ctrl_q;
  logic [1:0]       ctrl_d;
  logic [31:0]      rdata_q;
  logic [31:0]      rdata_d;

  logic [ACC_W-1:0] op;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   diff;
  logic [ACC_W-1:0] alu_res;
  logic             alu_ovf;
  logic             status_wr;
  logic             clr_all;
  logic             unused_wdata;

  assign unused_wdata = ^avs_writedata[31:2];

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_acc_btn (
    .clk_i   (clk_clk),
    .rst_i   (reset_reset),
    .btn_n_i (acc_btn_n),
    .press_o (acc_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_btn (
    .clk_i   (clk_clk),
    .rst_i   (reset_reset),
    .btn_n_i (clr_btn_n),
    .press_o (clr_press)
  );

  // The extra carry/borrow bit of sum/diff doubles as the overflow indication.
  always_comb begin
    op   = ACC_W'(sw_sync_q);
    sum  = {1'b0, acc_q} + {1'b0, op};
    diff = {1'b0, acc_q} - {1'b0, op};
    if (ctrl_q[CTRL_SUB]) begin
      alu_ovf = diff[ACC_W];
      alu_res = (alu_ovf && ctrl_q[CTRL_SAT]) ? '0 : diff[ACC_W-1:0];
    end else begin
      alu_ovf = sum[ACC_W];
      alu_res = (alu_ovf && ctrl_q[CTRL_SAT]) ? '1 : sum[ACC_W-1:0];
    end
  end

  assign status_wr = avs_write && (avs_address == ADDR_STATUS);
  assign clr_all   = clr_evt_q || (status_wr && avs_writedata[ST_CLR]);

  // A clear beats an accumulate; an overflow set beats a W1C in the same cycle.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr_all) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (status_wr && avs_writedata[ST_OVF]) begin
        ovf_d = 1'b0;
      end
      if (acc_evt_q) begin
        acc_d = alu_res;
        if (alu_ovf) begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (avs_write && (avs_address == ADDR_CTRL)) begin
      ctrl_d = avs_writedata[1:0];
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      rdata_d = '0;
      case (avs_address)
        ADDR_ACC:    rdata_d = 32'(acc_q);
        ADDR_STATUS: rdata_d[ST_OVF] = ovf_q;
        ADDR_CTRL:   rdata_d[1:0] = ctrl_q;
        ADDR_SWVAL:  rdata_d = 32'(sw_sync_q);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      acc_evt_q <= 1'b0;
      clr_evt_q <= 1'b0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      ctrl_q    <= '0;
      rdata_q   <= '0;
    end else begin
      sw_meta_q <= sw_export;
      sw_sync_q <= sw_meta_q;
      acc_evt_q <= acc_press;
      clr_evt_q <= clr_press;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      ctrl_q    <= ctrl_d;
      rdata_q   <= rdata_d;
    end
  end

  assign acc_value    = acc_q;
  assign led_export   = acc_q[LED_W-1:0];
  assign ovf          = ovf_q;
  assign avs_readdata = rdata_q;

endmodule

// File: doc/sw_accumulator_pio.md
Name: sw_accumulator_pio

Overview:
- Parametrised accumulator peripheral for the Nios II SoC, replacing the fixed 8-bit switch/LED accumulate pair.
- Synchronises and debounces two raw active-low pushbuttons (accumulate, clear) and adds or subtracts the switch value into an ACC_W-bit accumulator.
- Wrap or saturate mode is selectable; a sticky overflow flag records carry or borrow.
- The low bits of the accumulator drive the LEDs, and a small Avalon-MM slave gives software readback and control.

Parameters:
- SW_W, 8, switch input width; 1..ACC_W.
- ACC_W, 16, accumulator width; SW_W..32.
- LED_W, 8, LED output width; 1..ACC_W.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a button change; ≥2.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- sw_export  in  SW_W  raw switches, asynchronous to clk_clk.
- acc_btn_n  in  1  raw accumulate button, active-low.
- clr_btn_n  in  1  raw clear button, active-low.
- led_export  out  LED_W  acc[LED_W-1:0].
- acc_value  out  ACC_W  accumulator value.
- ovf  out  1  sticky overflow/borrow flag.
- avs_address  in  2  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data; read latency 1.

Behaviour:
- Reset (asynchronous, active-high):
  - acc=0, ovf=0, ctrl=0, led_export=0, avs_readdata=0.
  - All synchroniser flops=1, sw synchroniser=0, debounced button states=1 (released), debounce counters=0.
- Input synchronisation:
  - sw_export passes through a 2-flop synchroniser.
  - Each button passes through a 2-flop synchroniser and then a btn_debounce instance.
- Debounce:
  - The counter increments each cycle that the synchronised level differs from the stable state.
  - The counter clears to 0 on any cycle the levels match, so a bounce restarts the count.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable state flips at the next edge and the counter clears.
  - A press pulse (1 cycle, registered) fires on the cycle after the stable state goes 1→0. No pulse on release.
- Latency: first clock edge sampling raw=0 is edge 0; with no bounce the accumulator reflects the update after edge DEBOUNCE_CYCLES+4.
- Control register (ctrl):
  - bit0 SUB: 0=add, 1=subtract.
  - bit1 SAT: 0=wrap, 1=saturate.
- Accumulate pulse, with operand = zero-extended synchronised sw:
  - Add, wrap: acc=(acc+op) mod 2^ACC_W; ovf set if a carry occurs.
  - Add, saturate: acc=min(acc+op, 2^ACC_W-1); ovf set if clamped.
  - Sub, wrap: acc=(acc-op) mod 2^ACC_W; ovf set if op>acc.
  - Sub, saturate: acc=max(acc-op, 0); ovf set if op>acc.
  - ovf never clears on an accumulate.
- Clear pulse: acc=0, ovf=0.
- Simultaneous events:
  - Clear and accumulate pulses in the same cycle: clear wins.
  - Register write to ctrl in the same cycle as an accumulate: the accumulate uses the old ctrl.
- Register map (32-bit, unused bits read 0, writes to RO ignored):
  - 0 ACC (RO): zero-extended acc.
  - 1 STATUS: bit0 ovf, W1C.
  - 2 CTRL (RW): bits[1:0] as above.
  - 3 SWVAL (RO): synchronised sw, zero-extended.
  - Hardware ovf set in the same cycle as a W1C write: set wins.
  - Writing 1 to STATUS bit1 is a software clear: acc=0, ovf=0; it has the same priority as the button clear.
- Avalon timing:
  - avs_readdata is registered and returns the value current at the read edge, valid the next cycle.
  - avs_readdata holds its value when avs_read=0.
  - No waitrequest; writes take effect at the write edge.
- led_export and acc_value are combinational views of the acc register (no extra latency).
- Reset mid-debounce or mid-transaction: everything returns to reset values immediately, with no pulse emitted.

Decomposition:
- Package sw_acc_pkg holds:
  - register address constants ADDR_ACC=0, ADDR_STATUS=1, ADDR_CTRL=2, ADDR_SWVAL=3;
  - CTRL bit indices CTRL_SUB=0, CTRL_SAT=1;
  - STATUS bit indices ST_OVF=0, ST_CLR=1.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES): 2-flop sync, counter, stable state, registered press pulse. Instanced twice.
- The top level holds the synchronised sw, the ALU with its saturate/wrap mux, ovf, ctrl and the Avalon decode.

Test Plan (SW_W=8, ACC_W=8, LED_W=8, DEBOUNCE_CYCLES=4):
1. Reset, sw=0x05, clean acc press → acc=0x05 exactly 8 edges after the first sampled low, led_export=0x05, ovf=0. A second press → 0x0A.
2. Bounce: raw low 3 cycles, high 1, low 2, high → no pulse, acc unchanged. Then held low for 10 cycles → exactly one accumulate.
3. acc=0xF0, sw=0x20, wrap add → acc=0x10, ovf=1. Write STATUS=0x1 → ovf=0. Set SAT, acc=0xF0 plus 0x20 → acc=0xFF, ovf=1.
4. CTRL=SUB|SAT, acc=0x03, sw=0x05 → acc=0x00, ovf=1. CTRL=SUB, acc=0x03, sw=0x05 → acc=0xFE, ovf=1.
5. Accumulate and clear pulses aligned in the same cycle → acc=0, ovf=0. W1C write coinciding with an overflowing accumulate → ovf remains 1.
6. Avalon read addr 0 with acc=0x5A → readdata=0x0000005A one cycle later. Read addr 3 with sw=0xC3 → 0x000000C3. Assert reset mid-debounce → all outputs 0, no later pulse.
